three_input_or_checker: RTL and testbench

THREE_INPUT_OR_CHECKER -- requirements
Module: three_input_or_checker

---
 rtl/three_input_or_checker.sv | 154 +++++++++++++++
 tb/tb_three_input_or_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/three_input_or_checker.sv
`default_nettype none
// ============================================================================
//  Module      : three_input_or_checker
//  Description : Self-sweeping checker for a three-input OR gate built as
//                d = a|b, y = d|c. On a start request it drives the eight
//                {a,b,c} patterns 000..111 in turn, holds each for
//                HOLD_CYCLES clocks, and compares the gate's d_in/y_in
//                responses on the last cycle of every hold. It reports the
//                failing-pattern count, the first failing pattern and a
//                pass flag.
//
//  Ports       : clk            - rising-edge clock
//                rst_n          - asynchronous active-low reset
//                start          - one-cycle sweep request (ignored unless idle)
//                a, b, c        - registered stimulus (a = pattern MSB)
//                d_in, y_in     - gate responses (a|b) and (a|b|c)
//                busy           - high while patterns are being driven
//                done           - one-cycle pulse at sweep end
//                pass           - last sweep had no failing pattern
//                err_count      - failing patterns in last/current sweep
//                first_fail_vec - {a,b,c} of the first failing pattern
//                fail_seen      - a failure has occurred in this sweep
//
//  Revision    : 1.0 - initial release
// ============================================================================
module three_input_or_checker #(
    parameter int HOLD_CYCLES = 4  // 2..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       d_in,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail_vec,
    output logic       fail_seen
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRIVE = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [7:0] c_LAST_CNT = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0] c_LAST_PAT = 3'd7;

    logic [1:0] r_state;
    logic [2:0] r_pattern;
    logic [7:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err_count;
    logic [2:0] r_first_fail_vec;
    logic       r_fail_seen;

    logic       w_compare;
    logic       w_exp_d;
    logic       w_exp_y;
    logic       w_mismatch;
    logic [3:0] w_err_next;

    // Expected responses come straight from the pattern being driven.
    assign w_exp_d    = r_pattern[2] | r_pattern[1];
    assign w_exp_y    = r_pattern[2] | r_pattern[1] | r_pattern[0];
    assign w_compare  = (r_state == c_ST_DRIVE) && (r_cnt == c_LAST_CNT);
    // A pattern counts once even if both d and y are wrong.
    assign w_mismatch = (d_in != w_exp_d) || (y_in != w_exp_y);
    assign w_err_next = r_err_count + {3'd0, w_mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= c_ST_IDLE;
            r_pattern        <= 3'd0;
            r_cnt            <= 8'd0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_count      <= 4'd0;
            r_first_fail_vec <= 3'd0;
            r_fail_seen      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state          <= c_ST_DRIVE;
                        r_pattern        <= 3'd0;
                        r_cnt            <= 8'd0;
                        r_busy           <= 1'b1;
                        r_pass           <= 1'b0;
                        r_err_count      <= 4'd0;
                        r_first_fail_vec <= 3'd0;
                        r_fail_seen      <= 1'b0;
                    end
                end

                c_ST_DRIVE: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_compare) begin
                        r_err_count <= w_err_next;
                        if (w_mismatch && !r_fail_seen) begin
                            r_first_fail_vec <= r_pattern;
                            r_fail_seen      <= 1'b1;
                        end
                        if (r_pattern == c_LAST_PAT) begin
                            // Final pattern: result of this compare is
                            // already folded into the pass decision.
                            r_state   <= c_ST_DONE;
                            r_pattern <= 3'd0;
                            r_cnt     <= 8'd0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_pass    <= (w_err_next == 4'd0);
                        end else begin
                            r_pattern <= r_pattern + 3'd1;
                            r_cnt     <= 8'd0;
                        end
                    end
                end

                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state   <= c_ST_IDLE;
                    r_pattern <= 3'd0;
                    r_cnt     <= 8'd0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign a              = r_pattern[2];
    assign b              = r_pattern[1];
    assign c              = r_pattern[0];
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err_count;
    assign first_fail_vec = r_first_fail_vec;
    assign fail_seen      = r_fail_seen;

endmodule
`default_nettype wire

// File: tb/tb_three_input_or_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_three_input_or_checker
//  Description : Self-checking bench for three_input_or_checker. The gate
//                under test is modelled as two 8-entry response tables
//                indexed by {a,b,c}; the expected sweep results are derived
//                from those tables against the arithmetic truth of OR.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_three_input_or_checker;

    localparam int c_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       a, b, c;
    logic       d_in, y_in;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] first_fail_vec;
    logic       fail_seen;

    // Gate responses, one bit per {a,b,c} pattern.
    logic [7:0] r_resp_d;
    logic [7:0] r_resp_y;

    int n_cmp;
    int n_err;

    three_input_or_checker #(.HOLD_CYCLES(c_HOLD)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .a              (a),
        .b              (b),
        .c              (c),
        .d_in           (d_in),
        .y_in           (y_in),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_vec (first_fail_vec),
        .fail_seen      (fail_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign d_in = r_resp_d[{a, b, c}];
    assign y_in = r_resp_y[{a, b, c}];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Healthy gate: d true for patterns >= 2 (a or b set), y true for any nonzero.
    task automatic set_golden();
        for (int p = 0; p < 8; p++) begin
            r_resp_d[p] = (p >= 2);
            r_resp_y[p] = (p != 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_abc"}, {29'd0, a, b, c}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_done"}, {31'd0, done}, 32'd0);
        check_val({tag, "_pass"}, {31'd0, pass}, 32'd0);
        check_val({tag, "_errcnt"}, {28'd0, err_count}, 32'd0);
        check_val({tag, "_ffv"}, {29'd0, first_fail_vec}, 32'd0);
        check_val({tag, "_fseen"}, {31'd0, fail_seen}, 32'd0);
    endtask

    // Full sweep with cycle-level checks; noisy=1 pulses start randomly
    // while busy and during the done cycle, which must have no effect.
    task automatic run_sweep(input string tag, input bit noisy);
        int         e_err;
        logic [2:0] e_ffv;
        bit         e_fs;
        e_err = 0;
        e_ffv = 3'd0;
        e_fs  = 1'b0;
        for (int p = 0; p < 8; p++) begin
            if ((r_resp_d[p] != (p >= 2)) || (r_resp_y[p] != (p != 0))) begin
                if (!e_fs) e_ffv = 3'(p);
                e_fs = 1'b1;
                e_err++;
            end
        end

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8 * c_HOLD; i++) begin
            check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check_val({tag, "_abc"}, {29'd0, a, b, c}, 32'(i / c_HOLD));
            check_val({tag, "_nodone"}, {31'd0, done}, 32'd0);
            start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        start = noisy ? 1'b1 : 1'b0;
        check_val({tag, "_done"}, {31'd0, done}, 32'd1);
        check_val({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_abc_end"}, {29'd0, a, b, c}, 32'd0);
        check_val({tag, "_errcnt"}, {28'd0, err_count}, 32'(e_err));
        check_val({tag, "_ffv"}, {29'd0, first_fail_vec}, {29'd0, e_ffv});
        check_val({tag, "_fseen"}, {31'd0, fail_seen}, {31'd0, e_fs});
        check_val({tag, "_pass"}, {31'd0, pass}, {31'd0, (e_err == 0)});
        @(negedge clk);
        start = 1'b0;
        check_val({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check_val({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_pass_hold"}, {31'd0, pass}, {31'd0, (e_err == 0)});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        set_golden();

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_all_zero("idle20");

        // Healthy gate, quiet and noisy start.
        run_sweep("golden", 1'b0);
        run_sweep("golden_noisy", 1'b1);

        // y stuck at 0: every nonzero pattern fails.
        set_golden();
        r_resp_y = 8'h00;
        run_sweep("y_stuck0", 1'b0);
        repeat (20) @(negedge clk);
        check_val("hold_errcnt", {28'd0, err_count}, 32'd7);
        check_val("hold_ffv", {29'd0, first_fail_vec}, 32'd1);
        check_val("hold_fseen", {31'd0, fail_seen}, 32'd1);
        check_val("hold_pass", {31'd0, pass}, 32'd0);
        check_val("hold_busy", {31'd0, busy}, 32'd0);

        // d forced 0 only at pattern 110.
        set_golden();
        r_resp_d[6] = 1'b0;
        run_sweep("d0_at_110", 1'b0);

        // Random response tables.
        for (int k = 0; k < 6; k++) begin
            r_resp_d = 8'($urandom);
            r_resp_y = 8'($urandom);
            run_sweep("random", (k % 2) == 1);
        end

        // Reset in the middle of pattern 011 aborts without a done pulse.
        set_golden();
        r_resp_y = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * c_HOLD + 1) @(negedge clk);
        check_val("pre_abort_abc", {29'd0, a, b, c}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("post_rst_nodone", {31'd0, done}, 32'd0);
            check_val("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        set_golden();
        run_sweep("after_abort", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout: observed running expected finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

endmodule
`default_nettype wire
